// File: rtl/fa_2b_adder.sv
// 2-bit ripple-carry adder built from two chained full-adder cells, with
// optional output registers (OUT_REG=1) or purely combinational outputs (OUT_REG=0).

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic half;

   assign half = a ^ b;
   assign s    = half ^ ci;
   assign co   = (a & b) | (ci & half);

endmodule

module fa_2b_adder #(
   parameter int OUT_REG = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic A0,
   input  logic A1,
   input  logic B0,
   input  logic B1,
   input  logic Cin,
   output logic S0,
   output logic S1,
   output logic Cout1
);

   logic sum0;
   logic sum1;
   logic carry1;
   logic carry2;

   fa_cell u_cell0 (
      .a  (A0),
      .b  (B0),
      .ci (Cin),
      .s  (sum0),
      .co (carry1)
   );

   fa_cell u_cell1 (
      .a  (A1),
      .b  (B1),
      .ci (carry1),
      .s  (sum1),
      .co (carry2)
   );

   generate
      if (OUT_REG != 0) begin : g_reg
         // Reset overrides everything, so X on the inputs cannot leak into the outputs while rst_n is low
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               S0    <= 1'b0;
               S1    <= 1'b0;
               Cout1 <= 1'b0;
            end else begin
               S0    <= sum0;
               S1    <= sum1;
               Cout1 <= carry2;
            end
         end
      end else begin : g_comb
         logic unused_ok;

         assign unused_ok = &{1'b0, clk, rst_n};
         assign S0        = sum0;
         assign S1        = sum1;
         assign Cout1     = carry2;
      end
   endgenerate

endmodule

// File: tb/tb_fa_2b_adder.sv
// Self-checking bench for fa_2b_adder: registered build checked through a
// scoreboard queue, combinational build checked in the same cycle.

module tb_fa_2b_adder;

   typedef struct {
      logic [1:0] a;
      logic [1:0] b;
      logic       cin;
      logic [2:0] expected;
   } vector_t;

   logic clk = 1'b0;
   logic rst_n;
   logic a0, a1, b0, b1, cin;
   logic s0r, s1r, coutr;
   logic s0c, s1c, coutc;

   int testsRun    = 0;
   int testsFailed = 0;
   logic [2:0] expQ[$];
   vector_t vectors[10];

   always #5 clk = ~clk;

   fa_2b_adder #(.OUT_REG(1)) dut_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .A0    (a0),
      .A1    (a1),
      .B0    (b0),
      .B1    (b1),
      .Cin   (cin),
      .S0    (s0r),
      .S1    (s1r),
      .Cout1 (coutr)
   );

   fa_2b_adder #(.OUT_REG(0)) dut_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .A0    (a0),
      .A1    (a1),
      .B0    (b0),
      .B1    (b1),
      .Cin   (cin),
      .S0    (s0c),
      .S1    (s1c),
      .Cout1 (coutc)
   );

   function automatic logic [2:0] refSum(input logic [1:0] a, input logic [1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {2'b00, c};
   endfunction

   task automatic checkOutput(input string name, input logic [2:0] actual, input logic [2:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got {Cout1,S1,S0}=%b, expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one add, queues its registered result and checks the combinational build at once
   task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b, input logic c, input string name);
      {a1, a0} = a;
      {b1, b0} = b;
      cin      = c;
      expQ.push_back(refSum(a, b, c));
      #1;
      checkOutput({name, "_comb"}, {coutc, s1c, s0c}, refSum(a, b, c));
   endtask

   task automatic popAndCheck(input string name);
      if (expQ.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL %s: scoreboard empty, got %b", name, {coutr, s1r, s0r});
      end else begin
         checkOutput({name, "_reg"}, {coutr, s1r, s0r}, expQ.pop_front());
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors[0] = '{2'b00, 2'b00, 1'b0, 3'b000};
      vectors[1] = '{2'b01, 2'b00, 1'b0, 3'b001};
      vectors[2] = '{2'b01, 2'b01, 1'b0, 3'b010};
      vectors[3] = '{2'b11, 2'b00, 1'b0, 3'b011};
      vectors[4] = '{2'b11, 2'b01, 1'b0, 3'b100};
      vectors[5] = '{2'b11, 2'b10, 1'b0, 3'b101};
      vectors[6] = '{2'b11, 2'b11, 1'b0, 3'b110};
      vectors[7] = '{2'b11, 2'b00, 1'b1, 3'b100};
      vectors[8] = '{2'b11, 2'b11, 1'b1, 3'b111};
      vectors[9] = '{2'b01, 2'b00, 1'b1, 3'b010};

      // Reset held with maximum operands while the clock runs
      rst_n = 1'b0;
      {a1, a0} = 2'b11;
      {b1, b0} = 2'b11;
      cin = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         checkOutput("reset_hold", {coutr, s1r, s0r}, 3'b000);
         checkOutput("reset_comb", {coutc, s1c, s0c}, 3'b111);
      end
      a0 = 1'bx;
      @(posedge clk);
      #1;
      checkOutput("reset_x_input", {coutr, s1r, s0r}, 3'b000);
      a0 = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         applyStimulus(vectors[i].a, vectors[i].b, vectors[i].cin, $sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d_table", i), refSum(vectors[i].a, vectors[i].b, vectors[i].cin),
                     vectors[i].expected);
         @(posedge clk);
         #1;
         popAndCheck($sformatf("vec%0d", i));
      end

      // Asynchronous reset mid-cycle drops the outputs before the next edge
      @(negedge clk);
      applyStimulus(2'b11, 2'b11, 1'b1, "pre_async");
      @(posedge clk);
      #1;
      popAndCheck("pre_async");
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_assert", {coutr, s1r, s0r}, 3'b000);
      @(posedge clk);
      #1;
      checkOutput("async_hold", {coutr, s1r, s0r}, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;

      // All 32 combinations back to back, with an in-flight result discarded by a reset pulse
      for (int i = 0; i < 32; i++) begin
         if (i == 16) begin
            @(negedge clk);
            applyStimulus(i[4:3], i[2:1], i[0], "inflight");
            #2;
            rst_n = 1'b0;
            expQ.delete();
            @(posedge clk);
            #1;
            checkOutput("inflight_discard", {coutr, s1r, s0r}, 3'b000);
            @(negedge clk);
            rst_n = 1'b1;
         end
         @(negedge clk);
         applyStimulus(i[4:3], i[2:1], i[0], $sformatf("exh%0d", i));
         @(posedge clk);
         #1;
         popAndCheck($sformatf("exh%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
